// File: rtl/line_clear_sequencer.sv
// Line-clear sequencer for a 23x10 stacked-tile board: scans bottom-up, removes
// every full row by shifting the rows above it down, and reports per-pass and running counts.
module line_clear_sequencer (
    input  logic         clk_50,
    input  logic         resetn,
    input  logic         start,
    input  logic         clear,
    input  logic [229:0] board_in,
    output logic         busy,
    output logic         done,
    output logic [229:0] board_out,
    output logic [4:0]   lines_cleared,
    output logic [9:0]   total_lines
);

    localparam int ROWS = 23;
    localparam int COLS = 10;

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t         state;
    state_t         state_n;
    logic [229:0]   work;
    logic [229:0]   work_shifted;
    logic [4:0]     row_ptr;
    logic [4:0]     pass_cnt;
    logic           row_full;
    logic           scan_last;

    function automatic logic [9:0] sat_add(input logic [9:0] acc, input logic [4:0] inc);
        logic [10:0] sum;
        sum = {1'b0, acc} + {6'b0, inc};
        return sum[10] ? 10'h3FF : sum[9:0];
    endfunction

    assign row_full  = (work[int'(row_ptr)*COLS +: COLS] == 10'h3FF);
    assign scan_last = (state == SCAN) && !row_full && (row_ptr == 5'd0);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Rows 1..row_ptr take the row above them; row 0 refills with empty cells.
    always_comb begin
        work_shifted           = work;
        work_shifted[COLS-1:0] = '0;
        for (int i = 1; i < ROWS; i++) begin
            if (i <= int'(row_ptr))
                work_shifted[i*COLS +: COLS] = work[(i-1)*COLS +: COLS];
        end
    end

    always_ff @(posedge clk_50 or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start) state_n = SCAN;
            SCAN: begin
                if (row_full)
                    state_n = SHIFT;
                else if (row_ptr == 5'd0)
                    state_n = DONE;
            end
            SHIFT: state_n = SCAN;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (clear)
            state_n = IDLE;
    end

    // Results are loaded on the edge entering DONE so they are valid while done is high.
    always_ff @(posedge clk_50 or negedge resetn) begin
        if (!resetn) begin
            work          <= '0;
            row_ptr       <= '0;
            pass_cnt      <= '0;
            board_out     <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else if (clear) begin
            total_lines <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work     <= board_in;
                        row_ptr  <= 5'd22;
                        pass_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (scan_last) begin
                        board_out     <= work;
                        lines_cleared <= pass_cnt;
                        total_lines   <= sat_add(total_lines, pass_cnt);
                    end else if (!row_full) begin
                        row_ptr <= row_ptr - 5'd1;
                    end
                end
                SHIFT: begin
                    work     <= work_shifted;
                    pass_cnt <= pass_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Directed bench for line_clear_sequencer: latency, compaction, counters, abort and reset.
module tb_line_clear_sequencer;

    logic         clk_50;
    logic         resetn;
    logic         start;
    logic         clear;
    logic [229:0] board_in;
    logic         busy;
    logic         done;
    logic [229:0] board_out;
    logic [4:0]   lines_cleared;
    logic [9:0]   total_lines;

    int vectors;
    int miscompares;

    line_clear_sequencer dut (
        .clk_50        (clk_50),
        .resetn        (resetn),
        .start         (start),
        .clear         (clear),
        .board_in      (board_in),
        .busy          (busy),
        .done          (done),
        .board_out     (board_out),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines)
    );

    initial begin
        clk_50 = 1'b0;
        forever #10 clk_50 = ~clk_50;
    end

    function automatic logic [229:0] set_row(input logic [229:0] b, input int r, input logic [9:0] v);
        logic [229:0] t;
        t = b;
        t[r*10 +: 10] = v;
        return t;
    endfunction

    // Starts a pass; edges = rising edges from the start-sampling edge to done (-1 on timeout).
    task automatic run_pass(input logic [229:0] b, output int edges);
        edges = -1;
        @(negedge clk_50);
        board_in = b;
        start    = 1'b1;
        @(posedge clk_50);
        #1 start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk_50);
            #1;
            if (done) begin
                edges = n;
                break;
            end
        end
        if (edges < 0)
            $display("FAIL run_pass timeout: no done within 200 edges");
        @(posedge clk_50);
        #1;
    endtask

    task automatic do_clear();
        @(negedge clk_50);
        clear = 1'b1;
        @(posedge clk_50);
        #1 clear = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; clear = 1'b0; board_in = '0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (board_out !== 230'd0) begin miscompares++; $display("FAIL reset_board_out: got %h want 0", board_out); end
        vectors++; if (lines_cleared !== 5'd0) begin miscompares++; $display("FAIL reset_lines: got %0d want 0", lines_cleared); end
        vectors++; if (total_lines !== 10'd0) begin miscompares++; $display("FAIL reset_total: got %0d want 0", total_lines); end
        repeat (2) @(posedge clk_50);
        @(negedge clk_50);
        resetn = 1'b1;
    endtask

    task automatic test_empty();
        int e;
        run_pass('0, e);
        vectors++; if (e !== 23) begin miscompares++; $display("FAIL empty_latency: got %0d want 23", e); end
        vectors++; if (lines_cleared !== 5'd0) begin miscompares++; $display("FAIL empty_lines: got %0d want 0", lines_cleared); end
        vectors++; if (board_out !== 230'd0) begin miscompares++; $display("FAIL empty_board: got %h want 0", board_out); end
        vectors++; if (total_lines !== 10'd0) begin miscompares++; $display("FAIL empty_total: got %0d want 0", total_lines); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_width: got %b want 0", done); end
    endtask

    task automatic test_single();
        int e;
        logic [229:0] b, exp;
        b   = set_row(set_row('0, 22, 10'h3FF), 21, 10'h001);
        exp = set_row('0, 22, 10'h001);
        run_pass(b, e);
        vectors++; if (e !== 25) begin miscompares++; $display("FAIL single_latency: got %0d want 25", e); end
        vectors++; if (lines_cleared !== 5'd1) begin miscompares++; $display("FAIL single_lines: got %0d want 1", lines_cleared); end
        vectors++; if (board_out !== exp) begin miscompares++; $display("FAIL single_board: got %h want %h", board_out, exp); end
        vectors++; if (total_lines !== 10'd1) begin miscompares++; $display("FAIL single_total: got %0d want 1", total_lines); end
    endtask

    task automatic test_nonadjacent();
        int e;
        logic [229:0] b, exp;
        b = set_row('0, 22, 10'h3FF);
        b = set_row(b, 21, 10'h3FF);
        b = set_row(b, 20, 10'h155);
        b = set_row(b, 19, 10'h3FF);
        b = set_row(b, 18, 10'h2AA);
        exp = set_row(set_row('0, 22, 10'h155), 21, 10'h2AA);
        run_pass(b, e);
        vectors++; if (e !== 29) begin miscompares++; $display("FAIL nonadj_latency: got %0d want 29", e); end
        vectors++; if (lines_cleared !== 5'd3) begin miscompares++; $display("FAIL nonadj_lines: got %0d want 3", lines_cleared); end
        vectors++; if (board_out !== exp) begin miscompares++; $display("FAIL nonadj_board: got %h want %h", board_out, exp); end
        vectors++; if (total_lines !== 10'd4) begin miscompares++; $display("FAIL nonadj_total: got %0d want 4", total_lines); end
    endtask

    task automatic test_full_board();
        int e;
        logic [229:0] b;
        b = '1;
        run_pass(b, e);
        vectors++; if (e !== 69) begin miscompares++; $display("FAIL full_latency: got %0d want 69", e); end
        vectors++; if (lines_cleared !== 5'd23) begin miscompares++; $display("FAIL full_lines: got %0d want 23", lines_cleared); end
        vectors++; if (board_out !== 230'd0) begin miscompares++; $display("FAIL full_board: got %h want 0", board_out); end
        vectors++; if (total_lines !== 10'd27) begin miscompares++; $display("FAIL full_total: got %0d want 27", total_lines); end
    endtask

    task automatic test_row0();
        int e;
        run_pass(set_row('0, 0, 10'h3FF), e);
        vectors++; if (e !== 25) begin miscompares++; $display("FAIL row0_latency: got %0d want 25", e); end
        vectors++; if (lines_cleared !== 5'd1) begin miscompares++; $display("FAIL row0_lines: got %0d want 1", lines_cleared); end
        vectors++; if (board_out !== 230'd0) begin miscompares++; $display("FAIL row0_board: got %h want 0", board_out); end
        vectors++; if (total_lines !== 10'd28) begin miscompares++; $display("FAIL row0_total: got %0d want 28", total_lines); end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        @(negedge clk_50);
        board_in = set_row(set_row('0, 22, 10'h3FF), 21, 10'h001);
        start    = 1'b1;
        @(posedge clk_50);
        #1 start = 1'b0;
        repeat (5) @(posedge clk_50);
        @(negedge clk_50);
        clear = 1'b1;
        @(posedge clk_50);
        #1 clear = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got busy=%b want 0", busy); end
        vectors++; if (total_lines !== 10'd0) begin miscompares++; $display("FAIL abort_total: got %0d want 0", total_lines); end
        for (int n = 0; n < 40; n++) begin
            @(posedge clk_50);
            #1;
            if (done) dones++;
        end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
        vectors++; if (lines_cleared !== 5'd1) begin miscompares++; $display("FAIL abort_lines_held: got %0d want 1", lines_cleared); end
        vectors++; if (board_out !== 230'd0) begin miscompares++; $display("FAIL abort_board_held: got %h want 0", board_out); end
    endtask

    task automatic test_ignore();
        int e, dones;
        e = -1;
        dones = 0;
        @(negedge clk_50);
        board_in = set_row('0, 22, 10'h3FF);
        start    = 1'b1;
        @(posedge clk_50);
        #1 start = 1'b0;
        board_in = '1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk_50);
            #1;
            if (n == 3) start = 1'b1;
            if (n == 5) start = 1'b0;
            if (done) begin
                e = n;
                break;
            end
        end
        board_in = '0;
        vectors++; if (e !== 25) begin miscompares++; $display("FAIL ignore_latency: got %0d want 25", e); end
        vectors++; if (lines_cleared !== 5'd1) begin miscompares++; $display("FAIL ignore_lines: got %0d want 1", lines_cleared); end
        vectors++; if (board_out !== 230'd0) begin miscompares++; $display("FAIL ignore_board: got %h want 0", board_out); end
        vectors++; if (total_lines !== 10'd1) begin miscompares++; $display("FAIL ignore_total: got %0d want 1", total_lines); end
        for (int n = 0; n < 30; n++) begin
            @(posedge clk_50);
            #1;
            if (done) dones++;
        end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL ignore_extra_done: got %0d pulses want 0", dones); end
    endtask

    task automatic test_saturation();
        int e, sum_edges;
        logic [229:0] b10, b4;
        b10 = '0;
        for (int r = 13; r <= 22; r++) b10 = set_row(b10, r, 10'h3FF);
        b4 = '0;
        for (int r = 19; r <= 22; r++) b4 = set_row(b4, r, 10'h3FF);
        do_clear();
        vectors++; if (total_lines !== 10'd0) begin miscompares++; $display("FAIL sat_clear: got %0d want 0", total_lines); end
        sum_edges = 0;
        for (int p = 0; p < 44; p++) begin
            run_pass('1, e);
            sum_edges += e;
        end
        vectors++; if (sum_edges !== 44*69) begin miscompares++; $display("FAIL sat_preload_latency: got %0d want %0d", sum_edges, 44*69); end
        run_pass(b10, e);
        vectors++; if (e !== 43) begin miscompares++; $display("FAIL sat_10row_latency: got %0d want 43", e); end
        vectors++; if (total_lines !== 10'd1022) begin miscompares++; $display("FAIL sat_preload: got %0d want 1022", total_lines); end
        run_pass(b4, e);
        vectors++; if (lines_cleared !== 5'd4) begin miscompares++; $display("FAIL sat_lines: got %0d want 4", lines_cleared); end
        vectors++; if (total_lines !== 10'd1023) begin miscompares++; $display("FAIL sat_clamp: got %0d want 1023", total_lines); end
        run_pass(b4, e);
        vectors++; if (total_lines !== 10'd1023) begin miscompares++; $display("FAIL sat_no_wrap: got %0d want 1023", total_lines); end
    endtask

    task automatic test_async_reset();
        int e, dones;
        dones = 0;
        @(negedge clk_50);
        board_in = set_row('0, 22, 10'h3FF);
        start    = 1'b1;
        @(posedge clk_50);
        #1 start = 1'b0;
        @(posedge clk_50);
        #5 resetn = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL areset_done: got %b want 0", done); end
        vectors++; if (board_out !== 230'd0) begin miscompares++; $display("FAIL areset_board: got %h want 0", board_out); end
        vectors++; if (lines_cleared !== 5'd0) begin miscompares++; $display("FAIL areset_lines: got %0d want 0", lines_cleared); end
        vectors++; if (total_lines !== 10'd0) begin miscompares++; $display("FAIL areset_total: got %0d want 0", total_lines); end
        @(negedge clk_50);
        resetn = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk_50);
            #1;
            if (done || busy) dones++;
        end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL areset_stays_idle: got %0d active cycles want 0", dones); end
        run_pass('0, e);
        vectors++; if (e !== 23) begin miscompares++; $display("FAIL areset_restart: got %0d want 23", e); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_empty();
        test_single();
        test_nonadjacent();
        test_full_board();
        test_row0();
        test_abort();
        test_ignore();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
